eth_vlg_rx_demux: RTL and testbench
===================================

# eth_vlg_rx_demux

Receive-side protocol demultiplexer. It takes the single decoded payload stream from the IP layer and steers each packet to one of N protocol handlers (ICMP/TCP/UDP by default), selected by an 8-bit protocol key sampled at start-of-frame. Unmatched, aborted and stalled packets are discarded and counted. It is the receive-direction counterpart of the TX arbitration mux and sits between the IPv4 receiver and the per-protocol receivers.

## Interface
- N, 3, number of output channels
- W, 8, per-packet metadata width
- KEYS, {8'd17, 8'd6, 8'd1}, packed [N-1:0][7:0] protocol key per channel (index 0 = 1, 1 = 6, 2 = 17)
- TIMEOUT, 1024, consecutive no-valid cycles mid-packet before abort; must be ≥ 2

- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- strm  in  stream_t  input beat: dat[7:0], val, sof, eof, err
- meta  in  W  packet metadata, sampled on the val&sof beat
- key  in  8  protocol key, sampled on the val&sof beat
- strm_out  out  stream_t [N]  per-channel output stream
- meta_out  out  [N][W]  per-channel metadata
- sel  out  N  one-hot channel currently owning a packet; 0 when none
- drop_cnt  out  16  saturating count of discarded or aborted packets

## Operation
- States: idle_s, active_s (forwarding to channel ind), drop_s (discarding).
- Match: the lowest index i with KEYS[i] == key wins. Duplicate keys resolve to the lowest index.
- idle_s, on val&sof:
  - match and !eof: forward the beat to ind, latch meta into meta_out[ind], sel = onehot(ind), go to active_s.
  - match and eof: forward the single-beat packet, stay in idle_s, sel stays 0.
  - no match: drop_cnt++. Go to drop_s if !eof; otherwise stay in idle_s.
- idle_s, on val without sof: beat ignored.
- active_s:
  - val&!sof: forward the beat, including dat, err and eof, to ind.
  - val&eof: also go to idle_s and clear sel.
  - val&sof (premature restart): emit an abort to ind (val=0, eof=1, err=1), drop_cnt++, go to drop_s. The new sof beat is not forwarded. If it also carries eof, go to idle_s instead.
- drop_s:
  - Beats are discarded.
  - val&eof: go to idle_s.
  - val&sof: evaluated exactly as in idle_s, which resynchronises on a new packet.
- Timeout: a counter clears on every val beat and increments on each val=0 cycle in active_s or drop_s. When it reaches TIMEOUT:
  - active_s: emit an abort to ind, drop_cnt++, go to idle_s.
  - drop_s: go to idle_s silently.
- Outputs:
  - Non-selected channels drive strm_out with all fields 0 every cycle.
  - meta_out[i] holds its value until the next accepted packet on channel i.
- drop_cnt saturates at 16'hFFFF.

## Timing
- All outputs are registered. A beat accepted at cycle t appears on strm_out[ind] at t+1.
- meta_out[ind] updates in the same cycle as the forwarded sof beat (t+1).
- sel rises with the output sof beat and falls in the cycle after the output eof beat or abort.
- The abort pulse is one cycle, at t+1 after the restart beat or the timeout cycle.
- drop_cnt updates at t+1 after the triggering beat.
- The input is always accepted; there is no backpressure.
- Reset values:
  - every strm_out field 0
  - meta_out 0, sel 0, drop_cnt 0, timeout counter 0
  - state idle_s
- rst mid-packet returns to idle_s on the next edge. No abort pulse is emitted. The rest of that packet is ignored until the next sof.

## Test plan
- TCP packet:
  - Stimulus: key=6, meta=8'hA5, 20 beats dat=0..19, sof on beat 0, eof on beat 19.
  - Response: strm_out[1] reproduces all 20 beats delayed 1 cycle; meta_out[1]=8'hA5; sel=3'b010 for 20 cycles; channels 0/2 stay 0; drop_cnt=0.
- Unmatched key:
  - Stimulus: key=8'h99, 10-beat packet, then a UDP packet with key=17.
  - Response: no output for the first packet; drop_cnt=1; the UDP packet appears on strm_out[2] intact.
- Premature sof:
  - Stimulus: ICMP packet, sof again at beat 5, continuing to eof at beat 9.
  - Response: strm_out[0] carries beats 0–4, then one cycle val=0 eof=1 err=1; beats 5–9 are discarded; drop_cnt=1; sel returns to 0.
- Timeout:
  - Stimulus: TIMEOUT=8, UDP sof plus 3 beats, then val=0 for 8 cycles.
  - Response: abort pulse on strm_out[2] exactly 8 cycles after the last beat; drop_cnt=1; the next packet is accepted normally.
- Single-beat packets and back-to-back:
  - Stimulus: key=1 with sof&eof in one beat, immediately followed by a key=6 sof next cycle.
  - Response: one-beat output on channel 0, then channel 1 packet starting the next cycle with no gap.
- Saturation and reset:
  - Stimulus: force 65537 unmatched single-beat packets, then assert rst mid-TCP-packet.
  - Response: drop_cnt holds 16'hFFFF; after rst all outputs are 0 and the remaining beats are ignored until a new sof.

Source files
------------

// File: rtl/eth_vlg_rx_demux.sv
// Receive-side protocol demultiplexer: steers each IP payload packet to the
// handler whose protocol key matches, discarding and counting everything else.
package eth_vlg_rx_pkg;
  typedef struct packed {
    logic [7:0] dat;
    logic       val;
    logic       sof;
    logic       eof;
    logic       err;
  } stream_t;
endpackage

module eth_vlg_rx_demux
  import eth_vlg_rx_pkg::*;
#(
  parameter int                   N       = 3,
  parameter int                   W       = 8,
  parameter logic [N-1:0][7:0]    KEYS    = {8'd17, 8'd6, 8'd1},
  parameter int                   TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  stream_t               strm,
  input  logic [W-1:0]          meta,
  input  logic [7:0]            key,
  output stream_t [N-1:0]       strm_out,
  output logic [N-1:0][W-1:0]   meta_out,
  output logic [N-1:0]          sel,
  output logic [15:0]           drop_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam stream_t ABORT = '{dat: 8'h00, val: 1'b0, sof: 1'b0, eof: 1'b1, err: 1'b1};

  typedef enum logic [1:0] {idle_s, active_s, drop_s} state_t;

  state_t               state, state_n;
  logic [IW-1:0]        ind, ind_n;
  logic [TW-1:0]        tmo, tmo_n;
  stream_t [N-1:0]      strm_n;
  logic [N-1:0][W-1:0]  meta_n;
  logic [N-1:0]         sel_n;
  logic                 drop_inc;
  logic                 hit;
  logic [IW-1:0]        hit_idx;
  logic                 tmo_hit;

  // Scanning downwards lets the lowest matching index win on duplicate keys.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (KEYS[i] == key) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_n  = state;
    ind_n    = ind;
    tmo_n    = tmo;
    strm_n   = '0;
    meta_n   = meta_out;
    sel_n    = '0;
    drop_inc = 1'b0;
    tmo_hit  = !strm.val && (state != idle_s) && (tmo == TW'(TIMEOUT - 1));

    if (strm.val)
      tmo_n = '0;
    else if (state != idle_s)
      tmo_n = tmo + TW'(1);

    if (state == active_s) begin
      sel_n = N'(1) << ind;
      if (strm.val && strm.sof) begin
        strm_n[ind] = ABORT;
        drop_inc    = 1'b1;
        state_n     = strm.eof ? idle_s : drop_s;
      end else if (strm.val) begin
        strm_n[ind] = strm;
        if (strm.eof)
          state_n = idle_s;
      end else if (tmo_hit) begin
        strm_n[ind] = ABORT;
        drop_inc    = 1'b1;
        state_n     = idle_s;
        tmo_n       = '0;
      end
    end else if (strm.val && strm.sof) begin
      // idle_s and drop_s both resynchronise on any new start-of-frame.
      if (hit) begin
        strm_n[hit_idx] = strm;
        meta_n[hit_idx] = meta;
        ind_n           = hit_idx;
        if (!strm.eof) begin
          state_n = active_s;
          sel_n   = N'(1) << hit_idx;
        end else begin
          state_n = idle_s;
        end
      end else begin
        drop_inc = 1'b1;
        state_n  = strm.eof ? idle_s : drop_s;
      end
    end else if (state == drop_s) begin
      if (strm.val && strm.eof) begin
        state_n = idle_s;
      end else if (tmo_hit) begin
        state_n = idle_s;
        tmo_n   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= idle_s;
      ind      <= '0;
      tmo      <= '0;
      strm_out <= '0;
      meta_out <= '0;
      sel      <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_n;
      ind      <= ind_n;
      tmo      <= tmo_n;
      strm_out <= strm_n;
      meta_out <= meta_n;
      sel      <= sel_n;
      if (drop_inc && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_eth_vlg_rx_demux.sv
// Directed self-checking bench for eth_vlg_rx_demux with a short timeout so
// abort behaviour can be observed within a few cycles.
module tb_eth_vlg_rx_demux;
  import eth_vlg_rx_pkg::*;

  localparam int N = 3;
  localparam int W = 8;

  typedef stream_t [N-1:0] bus_t;

  logic                 clk = 1'b0;
  logic                 rst;
  stream_t              strm;
  logic [W-1:0]         meta;
  logic [7:0]           key;
  bus_t                 strm_out;
  logic [N-1:0][W-1:0]  meta_out;
  logic [N-1:0]         sel;
  logic [15:0]          drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  eth_vlg_rx_demux #(.N(N), .W(W), .KEYS({8'd17, 8'd6, 8'd1}), .TIMEOUT(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .strm     (strm),
    .meta     (meta),
    .key      (key),
    .strm_out (strm_out),
    .meta_out (meta_out),
    .sel      (sel),
    .drop_cnt (drop_cnt)
  );

  function automatic stream_t beat(input logic [7:0] d, input logic v, input logic s,
                                   input logic e, input logic r);
    return '{dat: d, val: v, sof: s, eof: e, err: r};
  endfunction

  function automatic bus_t onCh(input int ch, input stream_t b);
    bus_t x;
    x = '0;
    x[ch] = b;
    return x;
  endfunction

  // Drive one input cycle, then settle just after the edge that captures it.
  task automatic applyStimulus(input logic v, input logic s, input logic e, input logic r,
                               input logic [7:0] d, input logic [7:0] k, input logic [7:0] m);
    strm = '{dat: d, val: v, sof: s, eof: e, err: r};
    key  = k;
    meta = m;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    strm = '0;
    key  = '0;
    meta = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_strm", strm_out, '0);
    checkOutput("rst_meta", meta_out, '0);
    checkOutput("rst_sel", sel, '0);
    checkOutput("rst_drop", drop_cnt, '0);
    rst = 1'b0;

    $display("[TB] TCP packet");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, i == 0, i == 19, i == 10, 8'(i),
                    (i == 0) ? 8'd6 : 8'd0, (i == 0) ? 8'hA5 : 8'h00);
      checkOutput("tcp_beat", strm_out, onCh(1, beat(8'(i), 1'b1, i == 0, i == 19, i == 10)));
      checkOutput("tcp_sel", sel, 3'b010);
    end
    checkOutput("tcp_meta", meta_out[1], 8'hA5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("tcp_after_strm", strm_out, '0);
    checkOutput("tcp_after_sel", sel, '0);
    checkOutput("tcp_drop", drop_cnt, 16'd0);

    $display("[TB] unmatched key then UDP");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, i == 0, i == 9, 1'b0, 8'(i),
                    (i == 0) ? 8'h99 : 8'h00, 8'h5A);
      checkOutput("unm_quiet", strm_out, '0);
      checkOutput("unm_sel", sel, '0);
    end
    checkOutput("unm_drop", drop_cnt, 16'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i == 0, i == 3, 1'b0, 8'(8'h40 + i),
                    (i == 0) ? 8'd17 : 8'd0, (i == 0) ? 8'h3C : 8'h00);
      checkOutput("udp_beat", strm_out, onCh(2, beat(8'(8'h40 + i), 1'b1, i == 0, i == 3, 1'b0)));
    end
    checkOutput("udp_meta2", meta_out[2], 8'h3C);
    checkOutput("udp_meta1_hold", meta_out[1], 8'hA5);
    checkOutput("udp_meta0_hold", meta_out[0], 8'h00);
    checkOutput("udp_drop", drop_cnt, 16'd1);

    $display("[TB] premature sof");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, (i == 0) || (i == 5), i == 9, 1'b0, 8'(i),
                    ((i == 0) || (i == 5)) ? 8'd1 : 8'd0, 8'h11);
      if (i < 5) begin
        checkOutput("pre_beat", strm_out, onCh(0, beat(8'(i), 1'b1, i == 0, 1'b0, 1'b0)));
        checkOutput("pre_sel", sel, 3'b001);
      end else if (i == 5) begin
        checkOutput("pre_abort", strm_out, onCh(0, beat(8'h00, 1'b0, 1'b0, 1'b1, 1'b1)));
        checkOutput("pre_abort_sel", sel, 3'b001);
        checkOutput("pre_abort_drop", drop_cnt, 16'd2);
      end else begin
        checkOutput("pre_discard", strm_out, '0);
        checkOutput("pre_discard_sel", sel, '0);
      end
    end
    checkOutput("pre_drop", drop_cnt, 16'd2);

    $display("[TB] timeout");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, i == 0, 1'b0, 1'b0, 8'(8'h80 + i),
                    (i == 0) ? 8'd17 : 8'd0, (i == 0) ? 8'hC3 : 8'h00);
      checkOutput("tmo_beat", strm_out, onCh(2, beat(8'(8'h80 + i), 1'b1, i == 0, 1'b0, 1'b0)));
    end
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      if (k < 8) begin
        checkOutput("tmo_wait", strm_out, '0);
        checkOutput("tmo_wait_sel", sel, 3'b100);
      end else if (k == 8) begin
        checkOutput("tmo_abort", strm_out, onCh(2, beat(8'h00, 1'b0, 1'b0, 1'b1, 1'b1)));
        checkOutput("tmo_abort_sel", sel, 3'b100);
        checkOutput("tmo_drop", drop_cnt, 16'd3);
      end else begin
        checkOutput("tmo_after", strm_out, '0);
        checkOutput("tmo_after_sel", sel, '0);
      end
    end

    $display("[TB] single-beat and back-to-back");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 8'd1, 8'h77);
    checkOutput("one_beat", strm_out, onCh(0, beat(8'h55, 1'b1, 1'b1, 1'b1, 1'b0)));
    checkOutput("one_sel", sel, '0);
    checkOutput("one_meta", meta_out[0], 8'h77);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h66, 8'd6, 8'h88);
    checkOutput("b2b_sof", strm_out, onCh(1, beat(8'h66, 1'b1, 1'b1, 1'b0, 1'b0)));
    checkOutput("b2b_sel", sel, 3'b010);
    checkOutput("b2b_meta", meta_out[1], 8'h88);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h67, 8'd0, 8'h00);
    checkOutput("b2b_eof", strm_out, onCh(1, beat(8'h67, 1'b1, 1'b0, 1'b1, 1'b0)));
    checkOutput("b2b_eof_sel", sel, 3'b010);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("b2b_idle_sel", sel, '0);
    checkOutput("b2b_drop", drop_cnt, 16'd3);

    $display("[TB] saturation and reset");
    for (int i = 0; i < 65537; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'(i), 8'h99, 8'h00);
    checkOutput("sat_drop", drop_cnt, 16'hFFFF);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h99, 8'h00);
    checkOutput("sat_hold", drop_cnt, 16'hFFFF);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'd6, 8'hE1);
    checkOutput("rst_pkt_sof", strm_out, onCh(1, beat(8'h01, 1'b1, 1'b1, 1'b0, 1'b0)));
    checkOutput("rst_pkt_meta", meta_out[1], 8'hE1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 8'h00, 8'h00);
    rst = 1'b0;
    checkOutput("mid_rst_strm", strm_out, '0);
    checkOutput("mid_rst_meta", meta_out, '0);
    checkOutput("mid_rst_sel", sel, '0);
    checkOutput("mid_rst_drop", drop_cnt, '0);
    for (int i = 4; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, i == 5, 1'b0, 8'(i), 8'd6, 8'h00);
      checkOutput("post_rst_ignored", strm_out, '0);
      checkOutput("post_rst_sel", sel, '0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h09, 8'd6, 8'h42);
    checkOutput("post_rst_new", strm_out, onCh(1, beat(8'h09, 1'b1, 1'b1, 1'b1, 1'b0)));
    checkOutput("post_rst_meta", meta_out[1], 8'h42);
    checkOutput("post_rst_drop", drop_cnt, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
